// File: rtl/core_pkg.sv
// Shared types and default widths for the fetch-stage control blocks.
// Provides the sequencer state encoding and the program-counter type.
// Imported by pc_sequencer and its return-address stack.
package core_pkg;

  localparam int PC_W  = 12;
  localparam int PTR_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: LIFO of return addresses for call/return.
// Latency: push/pop take effect on the clock edge; o_top is the current top, combinational.
// Ports: i_clr empties the stack; i_push/i_pop (never both in one cycle) with o_full/o_empty.
//        Push when full and pop when empty are ignored; the caller flags the error.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;

  assign w_wr_idx  = r_cnt[AW-1:0];
  // When full the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
  assign w_top_idx = w_wr_idx - AW'(1);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_top     = r_mem[w_top_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_push && !o_full) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full && !i_clr) begin
      r_mem[w_wr_idx] <= i_dat;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and control-flow sequencer for instruction fetch.
// Latency: PC is registered; a jump target seen in cycle N is on PC after the next edge.
// Ports: Start/Stall/Halt and Branch/Cond/Call/Ret strobes from the decoder; Jptr out to the
//        external jump table, Jump back from it; PC/Busy/Done/Stack_err registered outputs.
//        Stall freezes every piece of state; strobes during a stall are dropped.
module pc_sequencer #(
  parameter int PC_W     = core_pkg::PC_W,
  parameter int PTR_W    = core_pkg::PTR_W,
  parameter int RS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic [PTR_W-1:0] Br_ptr,
  input  logic             Branch,
  input  logic             Cond,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Halt,
  output logic [PTR_W-1:0] Jptr,
  input  logic [PC_W-1:0]  Jump,
  output logic [PC_W-1:0]  PC,
  output logic             Busy,
  output logic             Done,
  output logic             Stack_err
);

  import core_pkg::*;

  seq_state_t      r_state;
  seq_state_t      w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            r_err;
  logic            w_err_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_clr;
  logic [PC_W-1:0] w_top;
  logic            w_full;
  logic            w_empty;

  // Natural-width add: wraps modulo 2^PC_W, for both the next PC and the pushed return address.
  assign w_pc_inc = r_pc + PC_W'(1);

  assign Jptr      = Br_ptr;
  assign PC        = r_pc;
  assign Busy      = (r_state == RUN);
  assign Done      = (r_state == HALTED);
  assign Stack_err = r_err;

  ret_stack #(
    .DEPTH (RS_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_pc_inc),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    if (!Stall) begin
      unique case (r_state)
        IDLE: begin
          w_pc_nxt = '0;
          if (Start) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          // Strobe priority: halt, return, call, taken branch, sequential.
          if (Halt) begin
            w_state_nxt = HALTED;
          end else if (Ret) begin
            if (!w_empty) begin
              w_pop    = 1'b1;
              w_pc_nxt = w_top;
            end else begin
              w_pc_nxt  = w_pc_inc;
              w_err_nxt = 1'b1;
            end
          end else if (Call) begin
            // On overflow the return address is lost but the jump still happens.
            if (!w_full) begin
              w_push = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
            w_pc_nxt = Jump;
          end else if (Branch && Cond) begin
            w_pc_nxt = Jump;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
        HALTED: begin
          if (Start) begin
            w_state_nxt = RUN;
            w_pc_nxt    = '0;
            w_clr       = 1'b1;
            w_err_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_pc_nxt    = '0;
        end
      endcase
    end
  end

endmodule
